// File: rtl/sys_ctrl.sv
// sys_ctrl: byte-serial command sequencer between UART RX, register file,
// 16-bit ALU and UART TX FIFO.
// Optional feature macro: SYS_CTRL_ALU_CLK_GATE_EN. When defined, CLK_GATE_EN
// pulses only while the FSM is in ALU_RUN. When undefined, CLK_GATE_EN is held
// at 1 after reset, and result capture timing is the same.
module sys_ctrl #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] RX_P_DATA,
    input  logic              RX_D_VLD,
    output logic [ADDR_W-1:0] RF_Address,
    output logic              RF_WrEn,
    output logic              RF_RdEn,
    output logic [DATA_W-1:0] RF_WrData,
    input  logic [DATA_W-1:0] RF_RdData,
    input  logic              RF_RdData_Valid,
    output logic [3:0]        ALU_FUN,
    input  logic [15:0]       ALU_OUT,
    output logic              CLK_GATE_EN,
    output logic [DATA_W-1:0] TX_P_DATA,
    output logic              TX_D_VLD,
    input  logic              FIFO_FULL
);

    localparam int unsigned ALU_W = 16;
    localparam int unsigned FUN_W = 4;

    localparam logic [DATA_W-1:0] CMD_WR     = DATA_W'(8'hAA);
    localparam logic [DATA_W-1:0] CMD_RD     = DATA_W'(8'hBB);
    localparam logic [DATA_W-1:0] CMD_ALU_OP = DATA_W'(8'hCC);
    localparam logic [DATA_W-1:0] CMD_ALU    = DATA_W'(8'hDD);

    typedef enum logic [3:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_WAIT,
        OP_A,
        OP_B,
        FUN,
        ALU_RUN,
        ALU_CAPT,
        TX_LO,
        TX_HI
    } state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_nxt;
    logic [ALU_W-1:0]    res_q, res_nxt;
    logic                single_q, single_nxt;

    logic [ADDR_W-1:0]   addr_nxt;
    logic                wren_nxt;
    logic                rden_nxt;
    logic [DATA_W-1:0]   wrdata_nxt;
    logic [FUN_W-1:0]    fun_nxt;
    logic                gate_nxt;
    logic [DATA_W-1:0]   txdata_nxt;
    logic                txvld_nxt;

    // Next-state and next-output decode
    always_comb begin
        state_nxt   = state;
        wr_addr_nxt = wr_addr_q;
        res_nxt     = res_q;
        single_nxt  = single_q;
        addr_nxt    = RF_Address;
        wren_nxt    = 1'b0;
        rden_nxt    = 1'b0;
        wrdata_nxt  = RF_WrData;
        fun_nxt     = ALU_FUN;
        txdata_nxt  = TX_P_DATA;
        txvld_nxt   = 1'b0;
`ifdef SYS_CTRL_ALU_CLK_GATE_EN
        gate_nxt    = 1'b0;
`else
        gate_nxt    = 1'b1;
`endif

        case (state)
            IDLE: begin
                if (RX_D_VLD) begin
                    case (RX_P_DATA)
                        CMD_WR:     state_nxt = WR_ADDR;
                        CMD_RD:     state_nxt = RD_ADDR;
                        CMD_ALU_OP: state_nxt = OP_A;
                        CMD_ALU:    state_nxt = FUN;
                        default:    state_nxt = IDLE;
                    endcase
                end
            end
            WR_ADDR: begin
                if (RX_D_VLD) begin
                    wr_addr_nxt = ADDR_W'(RX_P_DATA);
                    state_nxt   = WR_DATA;
                end
            end
            WR_DATA: begin
                if (RX_D_VLD) begin
                    wren_nxt   = 1'b1;
                    addr_nxt   = wr_addr_q;
                    wrdata_nxt = RX_P_DATA;
                    state_nxt  = IDLE;
                end
            end
            RD_ADDR: begin
                if (RX_D_VLD) begin
                    rden_nxt  = 1'b1;
                    addr_nxt  = ADDR_W'(RX_P_DATA);
                    state_nxt = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (RF_RdData_Valid) begin
                    res_nxt    = ALU_W'(RF_RdData);
                    single_nxt = 1'b1;
                    state_nxt  = TX_LO;
                end
            end
            OP_A: begin
                if (RX_D_VLD) begin
                    wren_nxt   = 1'b1;
                    addr_nxt   = ADDR_W'(0);
                    wrdata_nxt = RX_P_DATA;
                    state_nxt  = OP_B;
                end
            end
            OP_B: begin
                if (RX_D_VLD) begin
                    wren_nxt   = 1'b1;
                    addr_nxt   = ADDR_W'(1);
                    wrdata_nxt = RX_P_DATA;
                    state_nxt  = FUN;
                end
            end
            FUN: begin
                if (RX_D_VLD) begin
                    fun_nxt   = FUN_W'(RX_P_DATA);
                    state_nxt = ALU_RUN;
`ifdef SYS_CTRL_ALU_CLK_GATE_EN
                    gate_nxt  = 1'b1;
`endif
                end
            end
            ALU_RUN: begin
                state_nxt = ALU_CAPT;
            end
            ALU_CAPT: begin
                res_nxt    = ALU_OUT;
                single_nxt = 1'b0;
                state_nxt  = TX_LO;
            end
            TX_LO: begin
                if (!FIFO_FULL) begin
                    txvld_nxt  = 1'b1;
                    txdata_nxt = DATA_W'(res_q);
                    state_nxt  = single_q ? IDLE : TX_HI;
                end
            end
            TX_HI: begin
                if (!FIFO_FULL) begin
                    txvld_nxt  = 1'b1;
                    txdata_nxt = DATA_W'(res_q >> DATA_W);
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, working registers and registered outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            wr_addr_q   <= '0;
            res_q       <= '0;
            single_q    <= 1'b0;
            RF_Address  <= '0;
            RF_WrEn     <= 1'b0;
            RF_RdEn     <= 1'b0;
            RF_WrData   <= '0;
            ALU_FUN     <= '0;
            CLK_GATE_EN <= 1'b0;
            TX_P_DATA   <= '0;
            TX_D_VLD    <= 1'b0;
        end else begin
            state       <= state_nxt;
            wr_addr_q   <= wr_addr_nxt;
            res_q       <= res_nxt;
            single_q    <= single_nxt;
            RF_Address  <= addr_nxt;
            RF_WrEn     <= wren_nxt;
            RF_RdEn     <= rden_nxt;
            RF_WrData   <= wrdata_nxt;
            ALU_FUN     <= fun_nxt;
            CLK_GATE_EN <= gate_nxt;
            TX_P_DATA   <= txdata_nxt;
            TX_D_VLD    <= txvld_nxt;
        end
    end

endmodule

// File: tb/tb_sys_ctrl.sv
// tb_sys_ctrl: frame-level bench for sys_ctrl with a register-file and ALU
// environment model and scoreboard queues for expected writes and TX bytes.
module tb_sys_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  RX_P_DATA;
    logic        RX_D_VLD;
    logic [3:0]  RF_Address;
    logic        RF_WrEn;
    logic        RF_RdEn;
    logic [7:0]  RF_WrData;
    logic [7:0]  RF_RdData;
    logic        RF_RdData_Valid;
    logic [3:0]  ALU_FUN;
    logic [15:0] ALU_OUT;
    logic        CLK_GATE_EN;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD;
    logic        FIFO_FULL;

    sys_ctrl dut (
        .CLK            (CLK),
        .RST            (RST),
        .RX_P_DATA      (RX_P_DATA),
        .RX_D_VLD       (RX_D_VLD),
        .RF_Address     (RF_Address),
        .RF_WrEn        (RF_WrEn),
        .RF_RdEn        (RF_RdEn),
        .RF_WrData      (RF_WrData),
        .RF_RdData      (RF_RdData),
        .RF_RdData_Valid(RF_RdData_Valid),
        .ALU_FUN        (ALU_FUN),
        .ALU_OUT        (ALU_OUT),
        .CLK_GATE_EN    (CLK_GATE_EN),
        .TX_P_DATA      (TX_P_DATA),
        .TX_D_VLD       (TX_D_VLD),
        .FIFO_FULL      (FIFO_FULL)
    );

    always #5 CLK = ~CLK;

    // Register file: one-cycle read latency, not cleared by RST
    logic [7:0] rf [16];
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            RF_RdData       <= 8'h00;
            RF_RdData_Valid <= 1'b0;
        end else begin
            if (RF_WrEn) rf[RF_Address] <= RF_WrData;
            RF_RdData_Valid <= RF_RdEn;
            if (RF_RdEn) RF_RdData <= rf[RF_Address];
        end
    end

    // ALU with registered output, clocked only while CLK_GATE_EN is high
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            ALU_OUT <= 16'h0000;
        end else if (CLK_GATE_EN) begin
            case (ALU_FUN)
                4'd0:    ALU_OUT <= 16'(rf[0]) + 16'(rf[1]);
                4'd1:    ALU_OUT <= 16'(rf[0]) - 16'(rf[1]);
                4'd2:    ALU_OUT <= 16'(rf[0]) * 16'(rf[1]);
                default: ALU_OUT <= 16'h0000;
            endcase
        end
    end

    typedef struct {
        logic [31:0] frame;
        int          nb;
        int          ntx;
        logic [15:0] res;
        int          nwr;
        logic [11:0] w0;
        logic [11:0] w1;
        int          nrd;
        logic [3:0]  rd_addr;
    } vec_t;

    vec_t        vecs [7];
    logic [7:0]  exp_tx [$];
    logic [11:0] exp_wr [$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int tx_seen = 0;
    int wr_seen = 0;
    int rd_seen = 0;
    int gate_hi = 0;
    int gate_low = 0;
    int first_tx_cyc = -1;
    int last_wr_cyc = -1;
    logic [3:0] last_rd_addr = 4'h0;

    function automatic vec_t mk(logic [31:0] frame, int nb, int ntx, logic [15:0] res,
                                int nwr, logic [11:0] w0, logic [11:0] w1,
                                int nrd, logic [3:0] rd_addr);
        vec_t v;
        v.frame = frame; v.nb = nb; v.ntx = ntx; v.res = res;
        v.nwr = nwr; v.w0 = w0; v.w1 = w1; v.nrd = nrd; v.rd_addr = rd_addr;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance one clock and score everything the DUT presented after the edge
    task automatic tick();
        logic       ff_edge;
        logic [7:0] e;
        logic [11:0] w;
        ff_edge = FIFO_FULL;
        @(posedge CLK);
        #1;
        cyc++;
        if (TX_D_VLD) begin
            tx_seen++;
            if (first_tx_cyc < 0) first_tx_cyc = cyc;
            check("tx_while_full", 32'(ff_edge), 32'd0);
            if (exp_tx.size() == 0) begin
                check("tx_unexpected", 32'(TX_D_VLD), 32'd0);
            end else begin
                e = exp_tx.pop_front();
                check("tx_byte", 32'(TX_P_DATA), 32'(e));
            end
        end
        if (RF_WrEn) begin
            wr_seen++;
            last_wr_cyc = cyc;
            if (exp_wr.size() == 0) begin
                check("wr_unexpected", 32'(RF_WrEn), 32'd0);
            end else begin
                w = exp_wr.pop_front();
                check("wr_addr_data", 32'({RF_Address, RF_WrData}), 32'(w));
            end
        end
        if (RF_RdEn) begin
            rd_seen++;
            last_rd_addr = RF_Address;
        end
        if (!RST) begin
            if (CLK_GATE_EN) gate_hi++;
            else gate_low++;
        end
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_byte(logic [7:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        tick();
        RX_D_VLD  = 1'b0;
        RX_P_DATA = 8'($urandom);
    endtask

    task automatic drain(int budget);
        int n = 0;
        while ((exp_tx.size() != 0 || exp_wr.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        check("drain_pending", 32'(exp_tx.size() + exp_wr.size()), 32'd0);
    endtask

    function automatic logic [27:0] outs();
        return {RF_Address, RF_WrEn, RF_RdEn, RF_WrData, ALU_FUN,
                CLK_GATE_EN, TX_P_DATA, TX_D_VLD};
    endfunction

    initial begin
        vec_t v;
        int   tx0, wr0, rd0, gate0, last_cyc, n;

        //         frame          nb ntx res       nwr w0       w1       nrd rd_addr
        vecs[0] = mk(32'hAA053C00, 3, 0, 16'h0000, 1, 12'h53C, 12'h000, 0, 4'h0);
        vecs[1] = mk(32'hBB050000, 2, 1, 16'h003C, 0, 12'h000, 12'h000, 1, 4'h5);
        vecs[2] = mk(32'hCC123400, 4, 2, 16'h0046, 2, 12'h012, 12'h134, 0, 4'h0);
        vecs[3] = mk(32'hDD020000, 2, 2, 16'h03A8, 0, 12'h000, 12'h000, 0, 4'h0);
        vecs[4] = mk(32'h55000000, 1, 0, 16'h0000, 0, 12'h000, 12'h000, 0, 4'h0);
        vecs[5] = mk(32'hAA1F5A00, 3, 0, 16'h0000, 1, 12'hF5A, 12'h000, 0, 4'h0);
        vecs[6] = mk(32'hBB2F0000, 2, 1, 16'h005A, 0, 12'h000, 12'h000, 1, 4'hF);

        RST       = 1'b1;
        RX_D_VLD  = 1'b0;
        RX_P_DATA = 8'h00;
        FIFO_FULL = 1'b0;
        tick();
        check("reset_outputs", 32'(outs()), 32'd0);
        #2 RST = 1'b0;
        idle(3);

        // Table-driven frames
        foreach (vecs[i]) begin
            v = vecs[i];
            tx0 = tx_seen; wr0 = wr_seen; rd0 = rd_seen; gate0 = gate_hi;
            if (v.nwr > 0) exp_wr.push_back(v.w0);
            if (v.nwr > 1) exp_wr.push_back(v.w1);
            if (v.ntx > 0) exp_tx.push_back(v.res[7:0]);
            if (v.ntx > 1) exp_tx.push_back(v.res[15:8]);
            first_tx_cyc = -1;
            for (int j = 0; j < v.nb; j++) begin
                send_byte(v.frame[31-8*j -: 8]);
                if (j < v.nb - 1) idle(2);
            end
            last_cyc = cyc;
            drain(60);
            idle(4);
            check($sformatf("v%0d_tx_count", i), 32'(tx_seen - tx0), 32'(v.ntx));
            check($sformatf("v%0d_wr_count", i), 32'(wr_seen - wr0), 32'(v.nwr));
            check($sformatf("v%0d_rd_count", i), 32'(rd_seen - rd0), 32'(v.nrd));
            if (v.nrd > 0)
                check($sformatf("v%0d_rd_addr", i), 32'(last_rd_addr), 32'(v.rd_addr));
            if (v.ntx > 0)
                check($sformatf("v%0d_tx_latency", i), 32'(first_tx_cyc - last_cyc), 32'd3);
            if (v.nwr > 0 && v.ntx == 0)
                check($sformatf("v%0d_wr_latency", i), 32'(last_wr_cyc - last_cyc), 32'd0);
`ifdef SYS_CTRL_ALU_CLK_GATE_EN
            check($sformatf("v%0d_gate_pulses", i), 32'(gate_hi - gate0),
                  (v.ntx == 2) ? 32'd1 : 32'd0);
`else
            check($sformatf("v%0d_gate_low", i), 32'(gate_low), 32'd0);
`endif
        end

        // Back-pressure: FIFO full across TX_LO, then again across TX_HI
        exp_tx.push_back(8'h46);
        exp_tx.push_back(8'h00);
        tx0 = tx_seen;
        send_byte(8'hDD);
        idle(2);
        send_byte(8'h00);
        FIFO_FULL = 1'b1;
        idle(10);
        check("bp_no_tx_while_full", 32'(tx_seen - tx0), 32'd0);
        FIFO_FULL = 1'b0;
        n = 0;
        while (tx_seen - tx0 < 1 && n < 20) begin
            tick();
            n++;
        end
        check("bp_first_byte_out", 32'(tx_seen - tx0), 32'd1);
        FIFO_FULL = 1'b1;
        idle(3);
        check("bp_hi_held", 32'(tx_seen - tx0), 32'd1);
        FIFO_FULL = 1'b0;
        drain(20);
        idle(4);
        check("bp_tx_count", 32'(tx_seen - tx0), 32'd2);

        // Byte arriving during ALU_CAPT is dropped; a following read is clean
        exp_tx.push_back(8'h46);
        exp_tx.push_back(8'h00);
        tx0 = tx_seen; wr0 = wr_seen;
        send_byte(8'hDD);
        idle(2);
        send_byte(8'h00);
        tick();
        send_byte(8'hAA);
        drain(20);
        idle(4);
        exp_tx.push_back(8'h3C);
        send_byte(8'hBB);
        idle(2);
        send_byte(8'h05);
        drain(20);
        idle(4);
        check("drop_tx_count", 32'(tx_seen - tx0), 32'd3);
        check("drop_wr_count", 32'(wr_seen - wr0), 32'd0);

        // Asynchronous reset between operand A and operand B
        exp_wr.push_back(12'h077);
        send_byte(8'hCC);
        idle(2);
        send_byte(8'h77);
        idle(2);
        check("pre_reset_wr", 32'(exp_wr.size()), 32'd0);
        #2 RST = 1'b1;
        #1;
        check("async_reset_outputs", 32'(outs()), 32'd0);
        tx0 = tx_seen; wr0 = wr_seen;
        idle(2);
        #2 RST = 1'b0;
        idle(2);
        exp_tx.push_back(8'h34);
        send_byte(8'hBB);
        idle(2);
        send_byte(8'h01);
        drain(20);
        idle(4);
        check("post_reset_tx_count", 32'(tx_seen - tx0), 32'd1);
        check("post_reset_wr_count", 32'(wr_seen - wr0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
